// File: rtl/rv32i_types.sv
// Shared RV32I out-of-order core types: instruction/control payloads and the
// ALU/CMP reservation-station entry layout.
package rv32i_types;

  localparam int unsigned XLEN                 = 32;
  localparam int unsigned ALU_RS_DEPTH_DEFAULT = 8;
  localparam int unsigned TAG_W_DEFAULT        = 6;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  typedef enum logic [2:0] {
    CMP_BEQ  = 3'd0,
    CMP_BNE  = 3'd1,
    CMP_BLT  = 3'd2,
    CMP_BGE  = 3'd3,
    CMP_BLTU = 3'd4,
    CMP_BGEU = 3'd5
  } cmp_op_t;

  typedef struct packed {
    alu_op_t alu_op;
    cmp_op_t cmp_op;
    logic    is_cmp;
    logic    use_imm;
    logic    use_pc;
  } ctrl_word_t;

  typedef struct packed {
    logic [XLEN-1:0]          pc;
    logic [XLEN-1:0]          imm;
    logic [4:0]               rd_arch;
    logic [TAG_W_DEFAULT-1:0] rd_tag;
    logic [XLEN-1:0]          rs1_data;
    logic [XLEN-1:0]          rs2_data;
  } ooo_instr_t;

  typedef struct packed {
    logic [TAG_W_DEFAULT-1:0] tag;
    logic                     rdy;
  } rs_src_t;

  typedef struct packed {
    logic       valid;
    ooo_instr_t instr;
    ctrl_word_t ctrl;
    rs_src_t    src1;
    rs_src_t    src2;
  } alu_rs_entry_t;

endpackage

// File: rtl/alu_cmp_rs_select.sv
// Issue picker for the ALU/CMP reservation station: one-hot grant over ready entries.
// ALU_CMP_RS_OLDEST_FIRST_EN selects the oldest ready entry; otherwise the lowest index wins.
module alu_cmp_rs_select #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AGE_W = 3
) (
  input  logic [DEPTH-1:0]            ready,
  input  logic [DEPTH-1:0][AGE_W-1:0] age,
  output logic [DEPTH-1:0]            sel_onehot,
  output logic                        any_valid
);

  assign any_valid = |ready;

`ifdef ALU_CMP_RS_OLDEST_FIRST_EN
  logic [AGE_W-1:0] best_age;
  logic             found;

  // Strictly-greater compare keeps the lowest index on an age tie.
  always_comb begin
    sel_onehot = '0;
    best_age   = '0;
    found      = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (ready[i] && (!found || (age[i] > best_age))) begin
        sel_onehot    = '0;
        sel_onehot[i] = 1'b1;
        best_age      = age[i];
        found         = 1'b1;
      end
    end
  end
`else
  logic unused_age;
  assign unused_age = ^age;

  always_comb begin
    sel_onehot = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (ready[i]) begin
        sel_onehot    = '0;
        sel_onehot[i] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/alu_cmp_rs.sv
// Reservation station for the ALU/CMP unit: holds dispatched ops, snoops the CDB
// for operands, issues operand-complete entries. Optional macro ALU_CMP_RS_OLDEST_FIRST_EN.
module alu_cmp_rs
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH = ALU_RS_DEPTH_DEFAULT,
  parameter int unsigned TAG_W = TAG_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     dispatch_valid,
  output logic                     dispatch_ready,
  input  ooo_instr_t               dispatch_instr,
  input  ctrl_word_t               dispatch_ctrl,
  input  logic [TAG_W-1:0]         dispatch_rs1_tag,
  input  logic                     dispatch_rs1_rdy,
  input  logic [TAG_W-1:0]         dispatch_rs2_tag,
  input  logic                     dispatch_rs2_rdy,
  input  logic                     cdb_valid,
  input  logic [TAG_W-1:0]         cdb_tag,
  input  logic [31:0]              cdb_data,
  output logic                     issue_valid,
  input  logic                     issue_ready,
  output ooo_instr_t               issue_instr,
  output ctrl_word_t               issue_ctrl,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;
  localparam int unsigned AGE_W = $clog2(DEPTH);

  // Entry tags use the package tag width, so TAG_W is expected to equal TAG_W_DEFAULT.
  alu_rs_entry_t entries_q [DEPTH];
  alu_rs_entry_t entries_d [DEPTH];
  alu_rs_entry_t new_entry;

  logic [DEPTH-1:0]            ready_vec;
  logic [DEPTH-1:0]            sel_onehot;
  logic [DEPTH-1:0][AGE_W-1:0] age_vec;
  logic                        any_ready;
  logic                        dispatch_fire;
  logic                        issue_fire;
  logic [IDX_W-1:0]            free_idx;
  logic [OCC_W-1:0]            occupancy_d;
  logic                        dispatch_ready_d;

  assign dispatch_fire = dispatch_valid & dispatch_ready;
  assign issue_fire    = issue_valid & issue_ready;

  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      ready_vec[i] = entries_q[i].valid & entries_q[i].src1.rdy & entries_q[i].src2.rdy;
    end
  end

  // Lowest-index empty slot receives the next dispatch.
  always_comb begin
    free_idx = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!entries_q[i].valid) free_idx = IDX_W'(i);
    end
  end

  alu_cmp_rs_select #(
    .DEPTH (DEPTH),
    .AGE_W (AGE_W)
  ) u_select (
    .ready      (ready_vec),
    .age        (age_vec),
    .sel_onehot (sel_onehot),
    .any_valid  (any_ready)
  );

  // Issue payload comes straight from the selected registered entry.
  always_comb begin
    issue_valid = any_ready;
    issue_instr = '0;
    issue_ctrl  = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (sel_onehot[i]) begin
        issue_instr = entries_q[i].instr;
        issue_ctrl  = entries_q[i].ctrl;
      end
    end
  end

  // Incoming entry, with a same-cycle CDB broadcast captured for missing sources.
  always_comb begin
    new_entry            = '0;
    new_entry.valid      = 1'b1;
    new_entry.instr      = dispatch_instr;
    new_entry.ctrl       = dispatch_ctrl;
    new_entry.src1.tag   = dispatch_rs1_tag;
    new_entry.src1.rdy   = dispatch_rs1_rdy;
    new_entry.src2.tag   = dispatch_rs2_tag;
    new_entry.src2.rdy   = dispatch_rs2_rdy;
    if (cdb_valid && !dispatch_rs1_rdy && (dispatch_rs1_tag == cdb_tag)) begin
      new_entry.instr.rs1_data = cdb_data;
      new_entry.src1.rdy       = 1'b1;
    end
    if (cdb_valid && !dispatch_rs2_rdy && (dispatch_rs2_tag == cdb_tag)) begin
      new_entry.instr.rs2_data = cdb_data;
      new_entry.src2.rdy       = 1'b1;
    end
  end

  // Next-state: wakeup, then issue clear, then dispatch write; flush overrides all.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      entries_d[i] = entries_q[i];
      if (entries_q[i].valid && cdb_valid) begin
        if (!entries_q[i].src1.rdy && (entries_q[i].src1.tag == cdb_tag)) begin
          entries_d[i].instr.rs1_data = cdb_data;
          entries_d[i].src1.rdy       = 1'b1;
        end
        if (!entries_q[i].src2.rdy && (entries_q[i].src2.tag == cdb_tag)) begin
          entries_d[i].instr.rs2_data = cdb_data;
          entries_d[i].src2.rdy       = 1'b1;
        end
      end
      if (issue_fire && sel_onehot[i]) entries_d[i] = '0;
      if (dispatch_fire && (free_idx == IDX_W'(i))) entries_d[i] = new_entry;
      if (flush) entries_d[i] = '0;
    end
  end

  always_comb begin
    occupancy_d = occupancy;
    if (flush) begin
      occupancy_d = '0;
    end else begin
      occupancy_d = occupancy + OCC_W'(dispatch_fire) - OCC_W'(issue_fire);
    end
    dispatch_ready_d = (occupancy_d < OCC_W'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) entries_q[i] <= '0;
      occupancy      <= '0;
      dispatch_ready <= 1'b1;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) entries_q[i] <= entries_d[i];
      occupancy      <= occupancy_d;
      dispatch_ready <= dispatch_ready_d;
    end
  end

`ifdef ALU_CMP_RS_OLDEST_FIRST_EN
  logic [AGE_W-1:0] age_q [DEPTH];
  logic [AGE_W-1:0] age_d [DEPTH];

  // New entry starts at age 0; every other live entry ages by one, saturating.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      age_d[i]   = age_q[i];
      age_vec[i] = age_q[i];
      if (dispatch_fire) begin
        if (free_idx == IDX_W'(i)) begin
          age_d[i] = '0;
        end else if (entries_q[i].valid && (age_q[i] != {AGE_W{1'b1}})) begin
          age_d[i] = age_q[i] + AGE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) age_q[i] <= age_d[i];
    end
  end
`else
  assign age_vec = '0;
`endif

endmodule

// File: tb/tb_alu_cmp_rs.sv
// Self-checking bench for alu_cmp_rs: directed vector table, hand-written corner
// sequences, then randomized traffic against a behavioural model.
module tb_alu_cmp_rs;
  import rv32i_types::*;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned TAG_W  = 6;
  localparam int unsigned OCC_W  = 4;
  localparam int unsigned CTRL_W = $bits(ctrl_word_t);
  localparam int unsigned CW     = 160;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             dispatch_valid;
  logic             dispatch_ready;
  ooo_instr_t       dispatch_instr;
  ctrl_word_t       dispatch_ctrl;
  logic [TAG_W-1:0] dispatch_rs1_tag;
  logic             dispatch_rs1_rdy;
  logic [TAG_W-1:0] dispatch_rs2_tag;
  logic             dispatch_rs2_rdy;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;
  logic             issue_valid;
  logic             issue_ready;
  ooo_instr_t       issue_instr;
  ctrl_word_t       issue_ctrl;
  logic [OCC_W-1:0] occupancy;

  alu_cmp_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .dispatch_valid   (dispatch_valid),
    .dispatch_ready   (dispatch_ready),
    .dispatch_instr   (dispatch_instr),
    .dispatch_ctrl    (dispatch_ctrl),
    .dispatch_rs1_tag (dispatch_rs1_tag),
    .dispatch_rs1_rdy (dispatch_rs1_rdy),
    .dispatch_rs2_tag (dispatch_rs2_tag),
    .dispatch_rs2_rdy (dispatch_rs2_rdy),
    .cdb_valid        (cdb_valid),
    .cdb_tag          (cdb_tag),
    .cdb_data         (cdb_data),
    .issue_valid      (issue_valid),
    .issue_ready      (issue_ready),
    .issue_instr      (issue_instr),
    .issue_ctrl       (issue_ctrl),
    .occupancy        (occupancy)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    flush            = 1'b0;
    dispatch_valid   = 1'b0;
    dispatch_instr   = '0;
    dispatch_ctrl    = '0;
    dispatch_rs1_tag = '0;
    dispatch_rs1_rdy = 1'b0;
    dispatch_rs2_tag = '0;
    dispatch_rs2_rdy = 1'b0;
    cdb_valid        = 1'b0;
    cdb_tag          = '0;
    cdb_data         = '0;
    issue_ready      = 1'b0;
  endtask

  task automatic drive_dispatch(input logic [31:0] d1, input logic [31:0] d2,
                                input logic [TAG_W-1:0] t1, input logic r1,
                                input logic [TAG_W-1:0] t2, input logic r2);
    dispatch_valid          = 1'b1;
    dispatch_instr          = '0;
    dispatch_instr.rs1_data = d1;
    dispatch_instr.rs2_data = d2;
    dispatch_ctrl           = '0;
    dispatch_ctrl.alu_op    = ALU_ADD;
    dispatch_rs1_tag        = t1;
    dispatch_rs1_rdy        = r1;
    dispatch_rs2_tag        = t2;
    dispatch_rs2_rdy        = r2;
  endtask

  // Directed vectors: inputs applied for one cycle, outputs expected after that edge.
  typedef struct {
    int unsigned fl, dv, d1, d2, t1, r1, t2, r2, cv, ct, cd, ir;
    int unsigned e_iv, e_occ, e_dr, e1, e2;
  } vec_t;
  localparam int NV = 17;
  vec_t vecs [NV];

  // Behavioural model: a bag of entries tagged with a dispatch sequence number.
  typedef struct {
    bit          v;
    ooo_instr_t  ins;
    ctrl_word_t  ctl;
    logic [TAG_W-1:0] t1, t2;
    bit          r1, r2;
    int unsigned seq;
  } ment_t;
  ment_t       m [DEPTH];
  int unsigned disp_cnt = 0;

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < int'(DEPTH); i++) if (m[i].v) c++;
    return c;
  endfunction

  // Oldest = most dispatches since it arrived (saturated); ties favour the lower slot.
  function automatic int model_pick();
    int          best     = -1;
    int unsigned best_age = 0;
    int unsigned a;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (m[i].v && m[i].r1 && m[i].r2) begin
        a = disp_cnt - m[i].seq - 1;
        if (a > DEPTH - 1) a = DEPTH - 1;
`ifdef ALU_CMP_RS_OLDEST_FIRST_EN
        if (best < 0 || a > best_age) begin
          best = i;
          best_age = a;
        end
`else
        if (best < 0) best = i;
`endif
      end
    end
    return best;
  endfunction

  function automatic ooo_instr_t rand_instr();
    ooo_instr_t r;
    r.pc       = $urandom;
    r.imm      = $urandom;
    r.rd_arch  = 5'($urandom);
    r.rd_tag   = TAG_W'($urandom);
    r.rs1_data = $urandom;
    r.rs2_data = $urandom;
    return r;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_first, exp_second;
    int p, cnt, free_i;
    bit dfire, ifire;
    ment_t ne;

    vecs[0]  = '{0,1,5,7,0,1,0,1,0,0,0,1,                       1,1,1,5,7};
    vecs[1]  = '{0,0,0,0,0,0,0,0,0,0,0,1,                       0,0,1,0,0};
    vecs[2]  = '{0,1,32'h99,1,3,0,0,1,0,0,0,1,                  0,1,1,0,0};
    vecs[3]  = '{0,0,0,0,0,0,0,0,0,0,0,1,                       0,1,1,0,0};
    vecs[4]  = '{0,0,0,0,0,0,0,0,1,3,32'hDEADBEEF,1,            1,1,1,32'hDEADBEEF,1};
    vecs[5]  = '{0,0,0,0,0,0,0,0,0,0,0,1,                       0,0,1,0,0};
    vecs[6]  = '{0,1,32'h11,32'h55,0,1,9,0,1,9,32'h42,1,        1,1,1,32'h11,32'h42};
    vecs[7]  = '{0,0,0,0,0,0,0,0,0,0,0,1,                       0,0,1,0,0};
    vecs[8]  = '{0,1,1,2,0,1,0,1,0,0,0,0,                       1,1,1,1,2};
    vecs[9]  = '{0,1,3,4,0,1,0,1,0,0,0,1,                       1,1,1,3,4};
    vecs[10] = '{0,0,0,0,0,0,0,0,0,0,0,1,                       0,0,1,0,0};
    vecs[11] = '{0,1,0,8,4,0,0,1,1,5,1,0,                       0,1,1,0,0};
    vecs[12] = '{0,0,0,0,0,0,0,0,1,4,32'h77,0,                  1,1,1,32'h77,8};
    vecs[13] = '{0,0,0,0,0,0,0,0,0,0,0,1,                       0,0,1,0,0};
    vecs[14] = '{0,1,0,0,12,0,12,0,0,0,0,0,                     0,1,1,0,0};
    vecs[15] = '{0,0,0,0,0,0,0,0,1,12,32'hABC,0,                1,1,1,32'hABC,32'hABC};
    vecs[16] = '{0,0,0,0,0,0,0,0,0,0,0,1,                       0,0,1,0,0};

    set_idle();
    rst_n = 1'b0;
    repeat (2) tick();
    chk("reset_occ", CW'(occupancy), CW'(0));
    chk("reset_dready", CW'(dispatch_ready), CW'(1));
    chk("reset_ivalid", CW'(issue_valid), CW'(0));
    chk("reset_iinstr", CW'(issue_instr), CW'(0));
    chk("reset_ictrl", CW'(issue_ctrl), CW'(0));
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) begin
      set_idle();
      flush       = (vecs[i].fl != 0);
      issue_ready = (vecs[i].ir != 0);
      if (vecs[i].dv != 0)
        drive_dispatch(vecs[i].d1, vecs[i].d2, TAG_W'(vecs[i].t1), vecs[i].r1 != 0,
                       TAG_W'(vecs[i].t2), vecs[i].r2 != 0);
      cdb_valid = (vecs[i].cv != 0);
      cdb_tag   = TAG_W'(vecs[i].ct);
      cdb_data  = vecs[i].cd;
      tick();
      chk($sformatf("vec%0d_ivalid", i), CW'(issue_valid), CW'(vecs[i].e_iv));
      chk($sformatf("vec%0d_occ", i), CW'(occupancy), CW'(vecs[i].e_occ));
      chk($sformatf("vec%0d_dready", i), CW'(dispatch_ready), CW'(vecs[i].e_dr));
      if (vecs[i].e_iv != 0) begin
        chk($sformatf("vec%0d_rs1", i), CW'(issue_instr.rs1_data), CW'(vecs[i].e1));
        chk($sformatf("vec%0d_rs2", i), CW'(issue_instr.rs2_data), CW'(vecs[i].e2));
        chk($sformatf("vec%0d_aluop", i), CW'(issue_ctrl.alu_op), CW'(ALU_ADD));
      end else begin
        chk($sformatf("vec%0d_iinstr_zero", i), CW'(issue_instr), CW'(0));
      end
    end

    // Fill to capacity with the issue side stalled.
    set_idle();
    for (int k = 0; k < int'(DEPTH); k++) begin
      drive_dispatch(32'(100 + k), 32'd0, '0, 1'b1, '0, 1'b1);
      tick();
      chk($sformatf("fill%0d_occ", k), CW'(occupancy), CW'(k + 1));
      chk($sformatf("fill%0d_dready", k), CW'(dispatch_ready), CW'(k < int'(DEPTH) - 1));
    end
    drive_dispatch(32'd999, 32'd0, '0, 1'b1, '0, 1'b1);
    tick();
    chk("full_ignored_occ", CW'(occupancy), CW'(DEPTH));
    chk("full_dready", CW'(dispatch_ready), CW'(0));
    chk("full_first_rs1", CW'(issue_instr.rs1_data), CW'(100));
    issue_ready = 1'b1;
    tick();
    chk("full_issue_occ", CW'(occupancy), CW'(DEPTH - 1));
    chk("full_issue_dready", CW'(dispatch_ready), CW'(1));
    chk("full_next_rs1", CW'(issue_instr.rs1_data), CW'(101));
    set_idle();
    flush = 1'b1;
    tick();
    chk("fill_flush_occ", CW'(occupancy), CW'(0));

    // Flush beats a same-cycle dispatch and a matching wakeup.
    set_idle();
    for (int k = 0; k < 4; k++) begin
      drive_dispatch(32'd0, 32'd1, TAG_W'(20 + k), 1'b0, '0, 1'b1);
      tick();
    end
    chk("wait4_occ", CW'(occupancy), CW'(4));
    chk("wait4_ivalid", CW'(issue_valid), CW'(0));
    drive_dispatch(32'h5A, 32'h5B, '0, 1'b1, '0, 1'b1);
    flush = 1'b1; cdb_valid = 1'b1; cdb_tag = TAG_W'(20); cdb_data = 32'h1234;
    issue_ready = 1'b1;
    tick();
    chk("flush_occ", CW'(occupancy), CW'(0));
    chk("flush_ivalid", CW'(issue_valid), CW'(0));
    chk("flush_dready", CW'(dispatch_ready), CW'(1));
    set_idle();
    for (int k = 0; k < 4; k++) begin
      cdb_valid = 1'b1; cdb_tag = TAG_W'(20 + k); cdb_data = 32'hF0;
      tick();
      chk($sformatf("post_flush%0d_ivalid", k), CW'(issue_valid), CW'(0));
    end
    chk("post_flush_occ", CW'(occupancy), CW'(0));

    // Age ordering: B (slot 1) is older than C refilled into slot 0.
    set_idle();
    drive_dispatch(32'h10, 32'd0, '0, 1'b1, '0, 1'b1);
    tick();
    drive_dispatch(32'hB0, 32'd0, TAG_W'(5), 1'b0, '0, 1'b1);
    tick();
    set_idle();
    issue_ready = 1'b1;
    tick();
    chk("age_x_gone_occ", CW'(occupancy), CW'(1));
    set_idle();
    drive_dispatch(32'hC0, 32'd0, '0, 1'b1, '0, 1'b1);
    cdb_valid = 1'b1; cdb_tag = TAG_W'(5); cdb_data = 32'hB5;
    tick();
    set_idle();
`ifdef ALU_CMP_RS_OLDEST_FIRST_EN
    exp_first = 32'hB5; exp_second = 32'hC0;
`else
    exp_first = 32'hC0; exp_second = 32'hB5;
`endif
    chk("age_occ2", CW'(occupancy), CW'(2));
    chk("age_first_rs1", CW'(issue_instr.rs1_data), CW'(exp_first));
    issue_ready = 1'b1;
    tick();
    chk("age_second_rs1", CW'(issue_instr.rs1_data), CW'(exp_second));
    tick();
    chk("age_drain_ivalid", CW'(issue_valid), CW'(0));

    // Asynchronous reset between clock edges clears state immediately.
    set_idle();
    drive_dispatch(32'h1, 32'h2, '0, 1'b1, '0, 1'b1);
    tick();
    set_idle();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_occ", CW'(occupancy), CW'(0));
    chk("async_rst_ivalid", CW'(issue_valid), CW'(0));
    chk("async_rst_dready", CW'(dispatch_ready), CW'(1));
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < int'(DEPTH); i++) m[i].v = 1'b0;
    disp_cnt = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      p   = model_pick();
      cnt = model_count();
      chk("rnd_occ", CW'(occupancy), CW'(cnt));
      chk("rnd_dready", CW'(dispatch_ready), CW'(cnt < int'(DEPTH)));
      chk("rnd_ivalid", CW'(issue_valid), CW'(p >= 0));
      chk("rnd_iinstr", CW'(issue_instr), (p >= 0) ? CW'(m[p].ins) : CW'(0));
      chk("rnd_ictrl", CW'(issue_ctrl), (p >= 0) ? CW'(m[p].ctl) : CW'(0));

      set_idle();
      flush            = ($urandom_range(0, 63) == 0);
      dispatch_valid   = ($urandom_range(0, 2) != 0);
      dispatch_instr   = rand_instr();
      dispatch_ctrl    = ctrl_word_t'(CTRL_W'($urandom));
      dispatch_rs1_tag = TAG_W'($urandom_range(0, 7));
      dispatch_rs2_tag = TAG_W'($urandom_range(0, 7));
      dispatch_rs1_rdy = 1'($urandom_range(0, 1));
      dispatch_rs2_rdy = 1'($urandom_range(0, 1));
      cdb_valid        = 1'($urandom_range(0, 1));
      cdb_tag          = TAG_W'($urandom_range(0, 7));
      cdb_data         = $urandom;
      issue_ready      = ($urandom_range(0, 99) < (((cyc / 300) % 2 == 1) ? 85 : 25));

      dfire  = dispatch_valid && (cnt < int'(DEPTH));
      ifire  = (p >= 0) && issue_ready;
      free_i = -1;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) if (!m[i].v) free_i = i;
      if (flush) begin
        for (int i = 0; i < int'(DEPTH); i++) m[i].v = 1'b0;
      end else begin
        if (cdb_valid) begin
          for (int i = 0; i < int'(DEPTH); i++) begin
            if (m[i].v && !m[i].r1 && m[i].t1 == cdb_tag) begin m[i].r1 = 1'b1; m[i].ins.rs1_data = cdb_data; end
            if (m[i].v && !m[i].r2 && m[i].t2 == cdb_tag) begin m[i].r2 = 1'b1; m[i].ins.rs2_data = cdb_data; end
          end
        end
        if (ifire) m[p].v = 1'b0;
        if (dfire) begin
          ne.v = 1'b1; ne.ins = dispatch_instr; ne.ctl = dispatch_ctrl;
          ne.t1 = dispatch_rs1_tag; ne.t2 = dispatch_rs2_tag;
          ne.r1 = dispatch_rs1_rdy; ne.r2 = dispatch_rs2_rdy;
          if (cdb_valid && !ne.r1 && ne.t1 == cdb_tag) begin ne.r1 = 1'b1; ne.ins.rs1_data = cdb_data; end
          if (cdb_valid && !ne.r2 && ne.t2 == cdb_tag) begin ne.r2 = 1'b1; ne.ins.rs2_data = cdb_data; end
          ne.seq = disp_cnt;
          disp_cnt++;
          m[free_i] = ne;
        end
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
